rda_add_arbiter: RTL and testbench

Round-robin arbiter and result router that shares one pipelined 32-bit KPG/parallel-prefix adder among `NREQ` requesters. It sits in front of the adder's operand pipeline register and behind its sum output. It issues at most one add per cycle and tracks each in-flight operation with a tag pipeline matched to the adder latency. It returns each sum to the issuing requester through a per-requester one-entry response buffer with valid/ready handshake.

---
 rtl/rda_add_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rda_add_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rda_add_arbiter.sv
// rda_add_arbiter: round-robin front end for one shared pipelined adder.
// Grants at most one requester per cycle, follows each issued op through
// a tag pipeline of adder-latency depth, and parks each returned sum in a
// one-entry response buffer owned by the issuing requester.
//
// Handshakes: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high. A response transfers in the cycle where
// rsp_valid[i] and rsp_ready[i] are both high. req_ready never depends on
// rsp_ready, and a requester is not granted again until its response has
// transferred.
module rda_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  add_valid,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*WIDTH-1:0] rsp_sum,
    output logic [NREQ-1:0]       rsp_cout,
    output logic [15:0]           issue_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  r_outstanding;
    logic [PW-1:0]    r_ptr;
    logic [LAT-1:0]   r_tag_v;
    logic [PW-1:0]    r_tag_idx [LAT];
    logic [NREQ-1:0]  r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_sum [NREQ];
    logic [NREQ-1:0]  r_rsp_cout;
    logic [15:0]      r_issue_cnt;

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_hs;
    logic [NREQ-1:0]  w_cap;
    logic [PW-1:0]    w_gidx;
    logic [PW-1:0]    w_ptr_nxt;
    logic             w_found;
    int               w_dist;
    int               w_best;

    // A requester with an op in flight or a response still buffered may not issue again.
    assign w_elig = req_valid & ~r_outstanding;

    // Round-robin pick: the eligible requester closest to r_ptr going upward wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NREQ - int'(r_ptr));
            if (w_elig[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_gidx  = PW'(j);
                w_found = 1'b1;
            end
        end
    end

    // Grant is suppressed while disabled or while reset is held.
    assign w_grant   = (w_found && en && rst) ? (NREQ'(1) << w_gidx) : '0;
    assign req_ready = w_grant;
    assign add_valid = |w_grant;
    assign w_ptr_nxt = (w_gidx == PW'(NREQ - 1)) ? '0 : (w_gidx + PW'(1));

    // Operand mux: OR of the granted lane, all-zero when nothing is granted.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grant[j]) begin
                add_a   = req_a[j*WIDTH +: WIDTH];
                add_b   = req_b[j*WIDTH +: WIDTH];
                add_cin = req_cin[j];
            end
        end
    end

    // Response handshake and result-capture strobes.
    assign w_hs  = r_rsp_valid & rsp_ready;
    assign w_cap = r_tag_v[LAT-1] ? (NREQ'(1) << r_tag_idx[LAT-1]) : '0;

    // Arbitration state: outstanding set and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= '0;
            r_ptr         <= '0;
        end else begin
            r_outstanding <= (r_outstanding & ~w_hs) | w_grant;
            if (add_valid) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Tag pipeline mirrors the adder so each sum is routed to its issuer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_v <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag_idx[s] <= '0;
            end
        end else begin
            r_tag_v[0]   <= add_valid;
            r_tag_idx[0] <= w_gidx;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s]   <= r_tag_v[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    // Response buffers: capture on tag arrival, release on handshake; data holds after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= '0;
            r_rsp_cout  <= '0;
            for (int j = 0; j < NREQ; j++) begin
                r_rsp_sum[j] <= '0;
            end
        end else begin
            r_rsp_valid <= (r_rsp_valid & ~w_hs) | w_cap;
            for (int j = 0; j < NREQ; j++) begin
                if (w_cap[j]) begin
                    r_rsp_sum[j]  <= add_sum;
                    r_rsp_cout[j] <= add_cout;
                end
            end
        end
    end

    // Saturating issue counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_cnt <= '0;
        end else if (add_valid && (r_issue_cnt != 16'hFFFF)) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    // Pack per-requester sums onto the flat response bus.
    always_comb begin
        rsp_sum = '0;
        for (int j = 0; j < NREQ; j++) begin
            rsp_sum[j*WIDTH +: WIDTH] = r_rsp_sum[j];
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_cout  = r_rsp_cout;
    assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_rda_add_arbiter.sv
// Bench for rda_add_arbiter. The bench plays the adder (a LAT-deep delay
// line of a+b+cin fed from add_*), and keeps a per-requester model of
// grants, pending results and buffered responses built from the
// round-robin and latency rules.
module tb_rda_add_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  add_valid;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [NREQ*WIDTH-1:0] rsp_sum;
    logic [NREQ-1:0]       rsp_cout;
    logic [15:0]           issue_cnt;

    rda_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .issue_cnt(issue_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int               cyc;
    int               m_ptr;
    bit               m_out [NREQ];
    int               m_rdy [NREQ];
    logic [WIDTH-1:0] m_new_sum [NREQ];
    logic             m_new_cout [NREQ];
    logic [WIDTH-1:0] m_shown_sum [NREQ];
    logic             m_shown_cout [NREQ];
    int               m_cnt;

    // Adder stand-in
    logic             sv [LAT];
    logic [WIDTH:0]   ss [LAT];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_out[i]        = 1'b0;
            m_rdy[i]        = 0;
            m_shown_sum[i]  = '0;
            m_shown_cout[i] = 1'b0;
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = $urandom;
            req_b[i*WIDTH +: WIDTH] = $urandom;
            req_cin[i]              = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock cycle: check at the falling edge, advance model and adder after the rising edge.
    task automatic tick();
        int               g;
        int               j;
        logic [NREQ-1:0]  exp_rdy;
        logic [NREQ-1:0]  exp_rv;
        logic [WIDTH:0]   s;
        logic             st_v;
        logic [WIDTH:0]   st_s;
        @(negedge clk);
        if (!rst) model_clear();
        g = -1;
        if (rst && en) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[j] && !m_out[j]) g = j;
            end
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("add_valid", 64'(add_valid), 64'(g >= 0));
        chk("add_a", 64'(add_a), (g >= 0) ? 64'(req_a[g*WIDTH +: WIDTH]) : 64'd0);
        chk("add_b", 64'(add_b), (g >= 0) ? 64'(req_b[g*WIDTH +: WIDTH]) : 64'd0);
        chk("add_cin", 64'(add_cin), (g >= 0) ? 64'(req_cin[g]) : 64'd0);
        for (int i = 0; i < NREQ; i++) begin
            exp_rv[i] = m_out[i] && (cyc >= m_rdy[i]);
            chk($sformatf("rsp_sum%0d", i), 64'(rsp_sum[i*WIDTH +: WIDTH]), 64'(m_shown_sum[i]));
            chk($sformatf("rsp_cout%0d", i), 64'(rsp_cout[i]), 64'(m_shown_cout[i]));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        chk("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
        st_v = add_valid;
        st_s = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rv[i] && rsp_ready[i]) m_out[i] = 1'b0;
                if (m_out[i] && (cyc + 1 == m_rdy[i])) begin
                    m_shown_sum[i]  = m_new_sum[i];
                    m_shown_cout[i] = m_new_cout[i];
                end
            end
            if (g >= 0) begin
                s = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]}
                    + {{WIDTH{1'b0}}, req_cin[g]};
                m_out[g]      = 1'b1;
                m_rdy[g]      = cyc + LAT + 1;
                m_new_sum[g]  = s[WIDTH-1:0];
                m_new_cout[g] = s[WIDTH];
                m_ptr         = (g + 1) % NREQ;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int k = LAT - 1; k > 0; k--) begin
            sv[k] = sv[k-1];
            ss[k] = ss[k-1];
        end
        sv[0] = st_v;
        ss[0] = st_s;
        add_sum  = sv[LAT-1] ? ss[LAT-1][WIDTH-1:0] : WIDTH'($urandom);
        add_cout = sv[LAT-1] ? ss[LAT-1][WIDTH] : 1'($urandom_range(0, 1));
    endtask

    initial begin
        // Reset and initial drive
        cyc = 0;
        model_clear();
        for (int k = 0; k < LAT; k++) begin
            sv[k] = 1'b0;
            ss[k] = '0;
        end
        add_sum   = '0;
        add_cout  = 1'b0;
        en        = 1'b1;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        rand_ops();
        #2 rst = 1'b0;

        // Reset held with random inputs
        repeat (3) begin
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            en        = 1'($urandom_range(0, 1));
            rand_ops();
            tick();
        end
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) tick();

        // Single op: all-ones plus one wraps to zero with carry-out
        req_a[0*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        req_b[0*WIDTH +: WIDTH] = 32'h0000_0001;
        req_cin[0]              = 1'b0;
        req_valid               = 4'b0001;
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("single_rsp_valid", 64'(rsp_valid[0]), 64'd1);
        chk("single_rsp_sum", 64'(rsp_sum[0 +: WIDTH]), 64'h0);
        chk("single_rsp_cout", 64'(rsp_cout[0]), 64'd1);
        chk("single_issue_cnt", 64'(issue_cnt), 64'd1);
        repeat (2) tick();

        // Full load
        req_valid = '1;
        rsp_ready = '1;
        repeat (24) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Round-robin pointer: grant req1, then req0 and req3 compete
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1001;
        #1 chk("rr_first_req3", 64'(req_ready), 64'b1000);
        tick();
        #1 chk("rr_next_req0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        repeat (8) tick();

        // Backpressure on requester 1
        req_valid = '1;
        rsp_ready = 4'b1101;
        repeat (10) begin
            rand_ops();
            tick();
        end
        rsp_ready = '1;
        repeat (8) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Reset with three ops in flight
        req_valid = 4'b0111;
        repeat (3) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        rst       = 1'b0;
        tick();
        rst = 1'b1;
        repeat (8) tick();
        chk("rst_mid_issue_cnt", 64'(issue_cnt), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = 4'b0100;
        rand_ops();
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'b0100);
        repeat (3) tick();

        // Randomized traffic with enable toggling and rare resets
        repeat (500) begin
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            en        = ($urandom_range(0, 9) < 8);
            rst       = ($urandom_range(0, 99) != 0);
            rand_ops();
            tick();
        end
        rst = 1'b1;
        en  = 1'b1;
        rsp_ready = '1;
        req_valid = '0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
